serializer_of_n_by_s_using_right_shift: RTL and testbench
=========================================================

// Module: serializer_of_N_by_S_using_right_shift
//
// PURPOSE
// Stage downstream of the N-by-S right shifters. It accepts an N-bit word over a
// valid/ready handshake and emits it LSB-first as S-bit chunks, one chunk per
// accepted output beat. Between beats the word register is shifted right by S
// with zero fill. Feeds narrow links such as UART and SPI payload paths.
//
// PARAMETERS
// N      8   input word width; N >= 1
// S      3   chunk width (shift per beat); 1 <= S <= N
// BEATS  derived (localparam) = (N + S - 1) / S, chunks per word
//
// PORTS
// clk         in   1    clock, all state on rising edge
// rst         in   1    asynchronous, active-high reset
// up_valid    in   1    up_data valid
// up_ready    out  1    block can accept a word this cycle
// up_data     in   N    word to serialize
// down_valid  out  1    down_data / down_last valid
// down_ready  in   1    consumer accepts the chunk this cycle
// down_data   out  S    current chunk = word_reg[S-1:0]
// down_last   out  1    current chunk is chunk BEATS-1 of the word
//
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE, word_reg=0, beat_cnt=0, down_valid=0,
//   down_data=0, down_last=0. Reset mid-word discards the word, and no further chunk
//   of that word appears.
// - up_fire = up_valid & up_ready; down_fire = down_valid & down_ready.
// - FSM: IDLE, SEND. down_valid = (state==SEND), taken directly from the register.
//   IDLE -> SEND on up_fire.
//   SEND -> SEND on down_fire with !down_last, which shifts the word.
//   SEND -> IDLE on down_fire with down_last and no up_fire.
//   SEND -> SEND (reload) on down_fire with down_last and up_fire.
// - up_ready = (state==IDLE) | (down_fire & down_last). This is combinational
//   from down_ready. Back-to-back words stream with no bubble.
// - On up_fire: word_reg <= up_data, beat_cnt <= 0.
// - On down_fire with !down_last: word_reg <= word_reg >> S (logical, zero fill),
//   beat_cnt <= beat_cnt + 1.
// - down_last = (beat_cnt == BEATS-1). beat_cnt width = max(1,$clog2(BEATS)).
// - Partial final chunk (N % S != 0): the upper S-(N%S) bits are 0, from the zero fill.
// - S == N: BEATS=1, every chunk has down_last=1, and up_ready follows down_ready.
// - Latency: the word is accepted at edge k. Chunk 0 is valid from edge k+1.
//   Chunk i is valid no earlier than edge k+1+i.
// - Backpressure: while down_valid & !down_ready, down_data, down_last and
//   word_reg hold stable. up_ready=0 in SEND unless the last chunk fires.
// - up_valid with up_ready=0 has no effect. Upstream must hold the word.
// - down_data in IDLE = word_reg[S-1:0] (don't-care), with down_valid=0.
//
// TESTING
// 1. N=8,S=3, up_data=8'hB6, down_ready=1 -> chunks 3'd6,3'd6,3'd2 on
//    consecutive cycles, down_last only on 3'd2, then IDLE.
// 2. Same word, down_ready=0 for 2 cycles on chunk 1 -> 3'd6 held stable with
//    down_valid=1, then 3'd2 with last, and no chunk is lost or duplicated.
// 3. Words 8'hB6 then 8'h01, up_valid held -> 6,6,2,1,0,0 with no bubble.
//    up_ready=1 exactly on the cycles with last firing.
// 4. rst pulsed asynchronously after chunk 0 of 8'hFF -> down_valid=0 at once.
//    Next word 8'h07 yields 7,0,0.
// 5. N=8,S=8, words 8'hA5,8'h3C -> one beat each, with down_last=1 on both.
// 6. Random words, random valid/ready, N=8,S=3 -> the chunk stream reassembles
//    to the input words, checked by a scoreboard.

Source files
------------

// File: rtl/serializer_of_n_by_s_using_right_shift.sv
// Accepts an N-bit word over valid/ready and emits it LSB-first as S-bit chunks,
// shifting the held word right by S (zero fill) after every accepted chunk.
module serializer_of_n_by_s_using_right_shift #(
    parameter int N = 8,
    parameter int S = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [N-1:0] up_data,
    output logic         down_valid,
    input  logic         down_ready,
    output logic [S-1:0] down_data,
    output logic         down_last
);
    localparam int BEATS = (N + S - 1) / S;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state;
    logic [N-1:0]   word_reg;
    logic [CW-1:0]  beat_cnt;
    logic           up_fire;
    logic           down_fire;

    assign down_valid = (state == SEND);
    assign down_data  = word_reg[S-1:0];
    // Qualified by valid so last stays low in IDLE (beat_cnt parks at LAST_BEAT).
    assign down_last  = down_valid & (beat_cnt == LAST_BEAT);
    assign down_fire  = down_valid & down_ready;
    // Reload in the same cycle the last chunk leaves, so words stream bubble-free.
    assign up_ready   = (state == IDLE) | (down_fire & down_last);
    assign up_fire    = up_valid & up_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            word_reg <= '0;
            beat_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (up_fire) begin
                        state    <= SEND;
                        word_reg <= up_data;
                        beat_cnt <= '0;
                    end
                end
                SEND: begin
                    if (down_fire) begin
                        if (!down_last) begin
                            word_reg <= word_reg >> S;
                            beat_cnt <= beat_cnt + 1'b1;
                        end else if (up_fire) begin
                            word_reg <= up_data;
                            beat_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serializer_of_n_by_s_using_right_shift.sv
// Directed and random checks of the serializer against a chunk-queue reference model.
module tb_serializer_of_n_by_s_using_right_shift;
    localparam int N = 8;
    localparam int S = 3;
    localparam int BEATS = (N + S - 1) / S;

    logic clk = 1'b0;
    logic rst;
    logic up_valid, up_ready, down_valid, down_ready, down_last;
    logic [N-1:0] up_data;
    logic [S-1:0] down_data;
    logic up_valid8, up_ready8, down_valid8, down_ready8, down_last8;
    logic [7:0] up_data8, down_data8;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } chunk_t;

    chunk_t       q[$];
    chunk_t       q8[$];
    logic [N-1:0] words[$];
    logic [N-1:0] asm_word;
    int           asm_idx;

    always #5 clk = ~clk;

    serializer_of_n_by_s_using_right_shift #(.N(N), .S(S)) dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
        .down_valid(down_valid), .down_ready(down_ready),
        .down_data(down_data), .down_last(down_last)
    );

    serializer_of_n_by_s_using_right_shift #(.N(8), .S(8)) dut8 (
        .clk(clk), .rst(rst),
        .up_valid(up_valid8), .up_ready(up_ready8), .up_data(up_data8),
        .down_valid(down_valid8), .down_ready(down_ready8),
        .down_data(down_data8), .down_last(down_last8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a word becomes BEATS chunks, chunk i = bits [i*S +: S], zero-padded.
    task automatic push_word(input logic [N-1:0] w);
        for (int i = 0; i < BEATS; i++) begin
            chunk_t c;
            c.data = 8'((w >> (i * S)) & ((1 << S) - 1));
            c.last = (i == BEATS - 1);
            q.push_back(c);
        end
        words.push_back(w);
    endtask

    task automatic tick(input logic uv, input logic [N-1:0] ud, input logic dr, output logic uf);
        logic ev, er, df;
        @(negedge clk);
        up_valid = uv; up_data = ud; down_ready = dr;
        #1;
        ev = (q.size() != 0);
        er = !ev || (q[0].last && dr);
        chk("down_valid", 32'(down_valid), 32'(ev));
        if (ev) begin
            chk("down_data", 32'(down_data), 32'(q[0].data));
            chk("down_last", 32'(down_last), 32'(q[0].last));
        end
        chk("up_ready", 32'(up_ready), 32'(er));
        df = ev && dr;
        uf = uv && er;
        if (df) begin
            asm_word = asm_word | (N'(down_data) << (asm_idx * S));
            asm_idx++;
            if (q[0].last) begin
                chk("reassembled", 32'(asm_word), 32'(words.pop_front()));
                asm_word = '0;
                asm_idx = 0;
            end
            void'(q.pop_front());
        end
        if (uf) push_word(ud);
    endtask

    task automatic tick8(input logic uv, input logic [7:0] ud, input logic dr, output logic uf);
        logic ev, er;
        chunk_t c;
        @(negedge clk);
        up_valid8 = uv; up_data8 = ud; down_ready8 = dr;
        #1;
        ev = (q8.size() != 0);
        er = !ev || dr;
        chk("s8_down_valid", 32'(down_valid8), 32'(ev));
        if (ev) begin
            chk("s8_down_data", 32'(down_data8), 32'(q8[0].data));
            chk("s8_down_last", 32'(down_last8), 32'(q8[0].last));
        end
        chk("s8_up_ready", 32'(up_ready8), 32'(er));
        if (ev && dr) void'(q8.pop_front());
        uf = uv && er;
        if (uf) begin
            c.data = ud; c.last = 1'b1;
            q8.push_back(c);
        end
    endtask

    task automatic send(input logic [N-1:0] w);
        logic uf;
        int n = 0;
        uf = 1'b0;
        while (!uf && n < 10) begin
            tick(1'b1, w, 1'b1, uf);
            n++;
        end
        chk("send_accepted", 32'(uf), 32'(1));
    endtask

    task automatic drain(input int n);
        logic uf;
        repeat (n) tick(1'b0, '0, 1'b1, uf);
    endtask

    initial begin
        logic         uf;
        logic         pend;
        logic [N-1:0] pw;
        rst = 1'b1;
        up_valid = 1'b0; up_data = '0; down_ready = 1'b0;
        up_valid8 = 1'b0; up_data8 = '0; down_ready8 = 1'b0;
        asm_word = '0; asm_idx = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_down_valid", 32'(down_valid), 0);
        chk("rst_down_data", 32'(down_data), 0);
        chk("rst_down_last", 32'(down_last), 0);
        chk("rst_up_ready", 32'(up_ready), 1);
        chk("rst_s8_down_last", 32'(down_last8), 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: single word, free-running consumer
        send(8'hB6);
        drain(4);

        // 2: stall two cycles on chunk 1
        send(8'hB6);
        tick(1'b0, '0, 1'b1, uf);
        tick(1'b0, '0, 1'b0, uf);
        tick(1'b0, '0, 1'b0, uf);
        drain(4);

        // 3: back-to-back words with up_valid held
        send(8'hB6);
        send(8'h01);
        drain(4);

        // 4: asynchronous reset after chunk 0
        send(8'hFF);
        tick(1'b0, '0, 1'b1, uf);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_down_valid", 32'(down_valid), 0);
        chk("arst_up_ready", 32'(up_ready), 1);
        q.delete(); words.delete(); q8.delete();
        asm_word = '0; asm_idx = 0;
        @(negedge clk);
        rst = 1'b0;
        send(8'h07);
        drain(4);

        // 5: S == N instance, one beat per word
        tick8(1'b1, 8'hA5, 1'b1, uf);
        chk("s8_accept_a5", 32'(uf), 1);
        tick8(1'b1, 8'h3C, 1'b1, uf);
        chk("s8_accept_3c", 32'(uf), 1);
        tick8(1'b0, 8'h00, 1'b0, uf);
        tick8(1'b1, 8'h99, 1'b0, uf);
        chk("s8_blocked", 32'(uf), 0);
        tick8(1'b0, 8'h00, 1'b1, uf);
        tick8(1'b0, 8'h00, 1'b1, uf);

        // 6: random traffic; upstream holds a word until it is taken
        pend = 1'b0; pw = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                pend = ($urandom_range(0, 2) != 0);
                pw = N'($urandom);
            end
            tick(pend, pw, ($urandom_range(0, 3) != 0), uf);
            if (uf) pend = 1'b0;
        end
        drain(6);
        chk("final_idle", 32'(down_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
